// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm clock.
// ALARM_TIMEKEEPER_SNOOZE_EN adds the SNOOZED state.
package alarm_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

`ifdef ALARM_TIMEKEEPER_SNOOZE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RINGING, ST_SNOOZED} alarm_state_e;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_RINGING} alarm_state_e;
`endif

  function automatic logic time_valid(input logic [HOUR_W-1:0] h, input logic [MIN_W-1:0] m);
    return (h <= HOUR_MAX) && (m <= MIN_MAX);
  endfunction
endpackage

// File: rtl/tick_divider.sv
// Free-running divider; tick is high for the last count of each TICK_DIV period.
module tick_divider #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/alarm_timekeeper.sv
// 24-hour clock with a single alarm, auto-stop after RING_SEC seconds.
// ALARM_TIMEKEEPER_SNOOZE_EN enables the snooze input.
module alarm_timekeeper
  import alarm_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              set_time,
  input  logic              set_alarm,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_minute,
  input  logic              alarm_en,
  input  logic              snooze,
  input  logic              alarm_off,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [SEC_W-1:0]  second,
  output logic              sec_tick,
  output logic              ringing
);
  localparam int RC_W = (RING_SEC > 1) ? $clog2(RING_SEC + 1) : 1;
  localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SEC - 1);

  logic [HOUR_W-1:0] hr_q, hr_d, inc_hr, al_hr_q, al_hr_d;
  logic [MIN_W-1:0]  min_q, min_d, inc_min, al_min_q, al_min_d;
  logic [SEC_W-1:0]  sec_q, sec_d, inc_sec;
  logic [RC_W-1:0]   ring_cnt_q, ring_cnt_d;
  alarm_state_e      state_q, state_d;
  logic              time_ok, load_time, load_alarm, adv, hit;

`ifdef ALARM_TIMEKEEPER_SNOOZE_EN
  localparam int SN_W = (SNOOZE_MIN * 60 > 1) ? $clog2(SNOOZE_MIN * 60 + 1) : 1;
  localparam logic [SN_W-1:0] SNOOZE_LOAD = SN_W'(SNOOZE_MIN * 60);
  logic [SN_W-1:0] snooze_cnt_q, snooze_cnt_d;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  assign time_ok    = time_valid(set_hour, set_minute);
  assign load_time  = set_time & time_ok;
  assign load_alarm = set_alarm & time_ok;
  // a tick coinciding with set_time is swallowed by the load
  assign adv        = sec_tick & ~load_time;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clock (clock),
    .reset (reset),
    .clr   (load_time),
    .tick  (sec_tick)
  );

  always_comb begin
    inc_sec = (sec_q == SEC_MAX) ? '0 : sec_q + 1'b1;
    inc_min = min_q;
    inc_hr  = hr_q;
    if (sec_q == SEC_MAX) begin
      inc_min = (min_q == MIN_MAX) ? '0 : min_q + 1'b1;
      if (min_q == MIN_MAX) inc_hr = (hr_q == HOUR_MAX) ? '0 : hr_q + 1'b1;
    end
    hr_d  = hr_q;
    min_d = min_q;
    sec_d = sec_q;
    if (load_time) begin
      hr_d  = set_hour;
      min_d = set_minute;
      sec_d = '0;
    end else if (adv) begin
      hr_d  = inc_hr;
      min_d = inc_min;
      sec_d = inc_sec;
    end
    al_hr_d  = load_alarm ? set_hour   : al_hr_q;
    al_min_d = load_alarm ? set_minute : al_min_q;
    hit = adv && (inc_sec == '0) && (inc_min == al_min_q) && (inc_hr == al_hr_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hr_q       <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      al_hr_q    <= '0;
      al_min_q   <= '0;
      ring_cnt_q <= '0;
      state_q    <= ST_IDLE;
    end else begin
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      al_hr_q    <= al_hr_d;
      al_min_q   <= al_min_d;
      ring_cnt_q <= ring_cnt_d;
      state_q    <= state_d;
    end
  end

`ifdef ALARM_TIMEKEEPER_SNOOZE_EN
  always_ff @(posedge clock) begin
    if (reset) snooze_cnt_q <= '0;
    else       snooze_cnt_q <= snooze_cnt_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
`ifdef ALARM_TIMEKEEPER_SNOOZE_EN
    snooze_cnt_d = snooze_cnt_q;
`endif
    case (state_q)
      ST_IDLE: if (hit && alarm_en) state_d = ST_RINGING;
      ST_RINGING: begin
`ifdef ALARM_TIMEKEEPER_SNOOZE_EN
        if (snooze) begin
          state_d      = ST_SNOOZED;
          snooze_cnt_d = SNOOZE_LOAD;
        end else
`endif
        if (adv) begin
          if (ring_cnt_q == RING_LAST) state_d = ST_IDLE;
          else                         ring_cnt_d = ring_cnt_q + 1'b1;
        end
      end
`ifdef ALARM_TIMEKEEPER_SNOOZE_EN
      ST_SNOOZED: if (adv) begin
        snooze_cnt_d = snooze_cnt_q - 1'b1;
        if (snooze_cnt_q <= SN_W'(1)) state_d = ST_RINGING;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (!alarm_en || load_alarm || alarm_off) state_d = ST_IDLE;
    // counters only live while their state persists
    if (state_d != ST_RINGING || state_q != ST_RINGING) ring_cnt_d = '0;
`ifdef ALARM_TIMEKEEPER_SNOOZE_EN
    if (state_d != ST_SNOOZED) snooze_cnt_d = '0;
`endif
  end

  always_comb begin
    ringing = (state_q == ST_RINGING);
    hour    = hr_q;
    minute  = min_q;
    second  = sec_q;
  end
endmodule

// File: tb/tb_alarm_timekeeper.sv
// Directed bench for alarm_timekeeper with TICK_DIV=4, RING_SEC=5, SNOOZE_MIN=1.
module tb_alarm_timekeeper;
  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       set_time = 1'b0, set_alarm = 1'b0;
  logic [4:0] set_hour = '0;
  logic [5:0] set_minute = '0;
  logic       alarm_en = 1'b0, snooze = 1'b0, alarm_off = 1'b0;
  logic [4:0] hour;
  logic [5:0] minute, second;
  logic       sec_tick, ringing;

  int compared = 0;
  int mismatched = 0;

  alarm_timekeeper #(.TICK_DIV(TD), .RING_SEC(5), .SNOOZE_MIN(1)) dut (
    .clock(clock), .reset(reset), .set_time(set_time), .set_alarm(set_alarm),
    .set_hour(set_hour), .set_minute(set_minute), .alarm_en(alarm_en),
    .snooze(snooze), .alarm_off(alarm_off), .hour(hour), .minute(minute),
    .second(second), .sec_tick(sec_tick), .ringing(ringing)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic ticks(input int n);
    step(n * TD);
  endtask

  task automatic set_t(input int h, input int m);
    set_hour = 5'(h); set_minute = 6'(m); set_time = 1'b1;
    step(1);
    set_time = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hour"}, 32'(hour), 32'(h));
    chk({tag, ".minute"}, 32'(minute), 32'(m));
    chk({tag, ".second"}, 32'(second), 32'(s));
  endtask

  initial begin
    @(negedge clock);
    step(2);
    reset = 1'b0;
    chk_time("reset", 0, 0, 0);
    chk("reset.sec_tick", 32'(sec_tick), 0);
    chk("reset.ringing", 32'(ringing), 0);

    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("tick_c%0d", k), 32'(sec_tick), (k == 4 || k == 8) ? 1 : 0);
      step(1);
    end
    chk("tick.second", 32'(second), 2);

    set_t(23, 59);
    chk_time("load2359", 23, 59, 0);
    step(60 * TD - 1);
    chk_time("pre_wrap", 23, 59, 59);
    chk("pre_wrap.tick", 32'(sec_tick), 1);
    step(1);
    chk_time("wrap", 0, 0, 0);
    set_t(24, 0);
    chk_time("bad_hour", 0, 0, 0);
    set_t(12, 60);
    chk_time("bad_min", 0, 0, 0);

    set_hour = 5'd7; set_minute = 6'd30; set_alarm = 1'b1; alarm_en = 1'b1;
    step(1);
    set_alarm = 1'b0;
    set_t(7, 29);
    ticks(59);
    chk_time("pre_alarm", 7, 29, 59);
    chk("pre_alarm.ring", 32'(ringing), 0);
    ticks(1);
    chk_time("alarm", 7, 30, 0);
    chk("alarm.ring", 32'(ringing), 1);
    ticks(4);
    chk("ring4.ring", 32'(ringing), 1);
    ticks(1);
    chk("ring5.ring", 32'(ringing), 0);

    set_t(7, 30);
    chk("settime_hit.ring", 32'(ringing), 0);
    step(8);
    chk("settime_hit2.ring", 32'(ringing), 0);

    set_t(7, 29);
    ticks(60);
    chk("snz_pre.ring", 32'(ringing), 1);
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
`ifdef ALARM_TIMEKEEPER_SNOOZE_EN
    chk("snz.ring", 32'(ringing), 0);
    step(238);
    chk("snz59.ring", 32'(ringing), 0);
    step(1);
    chk("snz60.ring", 32'(ringing), 1);
    alarm_off = 1'b1;
    step(1);
    alarm_off = 1'b0;
    chk("snz_off.ring", 32'(ringing), 0);
`else
    chk("snz.ring", 32'(ringing), 1);
    step(18);
    chk("snz_ign4.ring", 32'(ringing), 1);
    step(1);
    chk("snz_ign5.ring", 32'(ringing), 0);
`endif

    set_t(7, 29);
    ticks(60);
    chk("both_pre.ring", 32'(ringing), 1);
    set_hour = 5'd24; set_minute = 6'd0; set_alarm = 1'b1;
    step(1);
    set_alarm = 1'b0;
    chk("bad_alarm.ring", 32'(ringing), 1);
    snooze = 1'b1; alarm_off = 1'b1;
    step(1);
    snooze = 1'b0; alarm_off = 1'b0;
    chk("both.ring", 32'(ringing), 0);
    step(300);
    chk("both_late.ring", 32'(ringing), 0);

    set_t(7, 29);
    ticks(60);
    chk("rst_pre.ring", 32'(ringing), 1);
    reset = 1'b1;
    step(1);
    chk_time("rst_mid", 0, 0, 0);
    chk("rst_mid.tick", 32'(sec_tick), 0);
    chk("rst_mid.ring", 32'(ringing), 0);
    reset = 1'b0;
    set_t(7, 29);
    ticks(60);
    chk("rst_old_alarm.ring", 32'(ringing), 0);
    set_t(23, 59);
    ticks(60);
    chk_time("rst_midnight", 0, 0, 0);
    chk("rst_midnight.ring", 32'(ringing), 1);
    alarm_en = 1'b0;
    step(1);
    chk("en_off.ring", 32'(ringing), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
